// File: rtl/lte_dl_path_detrans.sv
// rtl/lte_dl_path_detrans.sv - LTE downlink antenna de-transposer (ping-pong reorder buffer + serializer)
//
// Purpose: takes one {second, first} sample-pair word per antenna slot and
// writes it into a two-bank buffer at the slot's physical position from
// i_ant_posinfo. Once a full 8-slot group is in a bank, it is read out in
// position order, two samples per position, as a 16-cycle burst.
//
// Ports:
//   clk            sole clock, rising edge
//   asy_rst_n      asynchronous active-low reset
//   i_ant_posinfo  nibble k [4k+2:4k] = physical position of slot k
//   i_fram_hd      frame header pulse, with the first valid word of a frame
//   i_ant8_sel     slot-0 marker of an 8-slot group (qualified by i_data_valid)
//   i_data         sample pair {second, first}
//   i_data_valid   word qualifier, at most one per 2 cycles
//   o_fram_hd      first output sample of a frame
//   o_ant_idx      physical position of o_data
//   o_data         serialized sample
//   o_data_valid   qualifies o_data / o_ant_idx / o_fram_hd
//   o_ovf          sticky overflow, group dropped because its bank was still full
//   o_resync       one-cycle pulse when a partial group is discarded
//
// Optional build macro LTE_DL_DETRANS_SWAP_EN: emit the second sample before
// the first within each position.

module lte_dl_path_detrans #(
    parameter int SAMP_W = 16
) (
    input  logic                  clk,
    input  logic                  asy_rst_n,
    input  logic [31:0]           i_ant_posinfo,
    input  logic                  i_fram_hd,
    input  logic                  i_ant8_sel,
    input  logic [2*SAMP_W-1:0]   i_data,
    input  logic                  i_data_valid,
    output logic                  o_fram_hd,
    output logic [2:0]            o_ant_idx,
    output logic [SAMP_W-1:0]     o_data,
    output logic                  o_data_valid,
    output logic                  o_ovf,
    output logic                  o_resync
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_READ = 1'b1;

    logic [31:0]          posinfo_q;
    logic [2:0]           wr_slot;
    logic                 synced;
    logic                 wr_bank;
    logic                 rd_bank;
    logic [7:0]           mask [2];
    logic [1:0]           full;
    logic [1:0]           hd_flag;
    logic [0:0]           state;
    logic [3:0]           rd_cnt;
    logic [2*SAMP_W-1:0]  mem [2][8];

    logic [31:0]          posinfo_eff;
    logic                 accept;
    logic [2:0]           slot_eff;
    logic [2:0]           wr_addr;
    logic                 resync_ev;
    logic                 wr_en;
    logic                 grp_done;
    logic [2*SAMP_W-1:0]  rd_word;
    logic                 sel_hi;
    logic [SAMP_W-1:0]    rd_sample;

    // The header word itself already uses the new map for its own slot.
    assign posinfo_eff = (i_data_valid && i_fram_hd) ? i_ant_posinfo : posinfo_q;
    // After reset nothing is accepted until a group start has been seen.
    assign accept      = i_data_valid && (synced || i_ant8_sel);
    assign slot_eff    = i_ant8_sel ? 3'd0 : wr_slot;
    assign wr_addr     = posinfo_eff[{slot_eff, 2'b00} +: 3];
    assign resync_ev   = i_data_valid && i_ant8_sel && synced && (wr_slot != 3'd0);
    // A bank still waiting for the reader is never overwritten; its group is lost instead.
    assign wr_en       = accept && !full[wr_bank];
    assign grp_done    = accept && (slot_eff == 3'd7);

    assign rd_word = mem[rd_bank][rd_cnt[3:1]];
`ifdef LTE_DL_DETRANS_SWAP_EN
    assign sel_hi  = ~rd_cnt[0];
`else
    assign sel_hi  = rd_cnt[0];
`endif
    assign rd_sample = sel_hi ? rd_word[2*SAMP_W-1:SAMP_W] : rd_word[SAMP_W-1:0];

    // Data storage has no reset; the written-masks gate every read.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_bank][wr_addr] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge asy_rst_n) begin
        if (!asy_rst_n) begin
            posinfo_q    <= '0;
            wr_slot      <= '0;
            synced       <= 1'b0;
            wr_bank      <= 1'b0;
            rd_bank      <= 1'b0;
            mask[0]      <= '0;
            mask[1]      <= '0;
            full         <= '0;
            hd_flag      <= '0;
            state        <= ST_IDLE;
            rd_cnt       <= '0;
            o_fram_hd    <= 1'b0;
            o_ant_idx    <= '0;
            o_data       <= '0;
            o_data_valid <= 1'b0;
            o_ovf        <= 1'b0;
            o_resync     <= 1'b0;
        end else begin
            o_resync <= resync_ev;

            if (i_data_valid && i_fram_hd) begin
                posinfo_q <= i_ant_posinfo;
            end
            if (i_data_valid && i_ant8_sel) begin
                synced <= 1'b1;
            end
            if (accept) begin
                wr_slot <= slot_eff + 3'd1;
            end

            // Slot 0 restarts the bank mask, which also discards any partial group.
            if (wr_en) begin
                if (slot_eff == 3'd0) begin
                    mask[wr_bank]    <= 8'd1 << wr_addr;
                    hd_flag[wr_bank] <= i_fram_hd;
                end else begin
                    mask[wr_bank][wr_addr] <= 1'b1;
                end
            end

            if (grp_done) begin
                if (full[wr_bank]) begin
                    o_ovf <= 1'b1;
                end else begin
                    full[wr_bank] <= 1'b1;
                    wr_bank       <= ~wr_bank;
                end
            end

            // The reader only touches rd_bank, which is full, so it never
            // collides with a writer update above.
            case (state)
                ST_IDLE: begin
                    rd_cnt <= '0;
                    if (full[rd_bank]) begin
                        state <= ST_READ;
                    end
                end
                default: begin
                    rd_cnt <= rd_cnt + 4'd1;
                    if (rd_cnt == 4'hF) begin
                        full[rd_bank]    <= 1'b0;
                        mask[rd_bank]    <= '0;
                        hd_flag[rd_bank] <= 1'b0;
                        rd_bank          <= ~rd_bank;
                        if (!full[~rd_bank]) begin
                            state <= ST_IDLE;
                        end
                    end
                end
            endcase

            if (state == ST_READ) begin
                o_data_valid <= 1'b1;
                o_ant_idx    <= rd_cnt[3:1];
                o_data       <= mask[rd_bank][rd_cnt[3:1]] ? rd_sample : '0;
                o_fram_hd    <= hd_flag[rd_bank] && (rd_cnt == 4'd0);
            end else begin
                o_data_valid <= 1'b0;
                o_ant_idx    <= '0;
                o_data       <= '0;
                o_fram_hd    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_lte_dl_path_detrans.sv
// tb/tb_lte_dl_path_detrans.sv - self-checking bench for lte_dl_path_detrans

module tb_lte_dl_path_detrans;

    localparam int SAMP_W = 16;

    logic                 clk = 1'b0;
    logic                 asy_rst_n;
    logic [31:0]          i_ant_posinfo;
    logic                 i_fram_hd;
    logic                 i_ant8_sel;
    logic [2*SAMP_W-1:0]  i_data;
    logic                 i_data_valid;
    logic                 o_fram_hd;
    logic [2:0]           o_ant_idx;
    logic [SAMP_W-1:0]    o_data;
    logic                 o_data_valid;
    logic                 o_ovf;
    logic                 o_resync;

    always #5 clk = ~clk;

    lte_dl_path_detrans #(.SAMP_W(SAMP_W)) dut (
        .clk          (clk),
        .asy_rst_n    (asy_rst_n),
        .i_ant_posinfo(i_ant_posinfo),
        .i_fram_hd    (i_fram_hd),
        .i_ant8_sel   (i_ant8_sel),
        .i_data       (i_data),
        .i_data_valid (i_data_valid),
        .o_fram_hd    (o_fram_hd),
        .o_ant_idx    (o_ant_idx),
        .o_data       (o_data),
        .o_data_valid (o_data_valid),
        .o_ovf        (o_ovf),
        .o_resync     (o_resync)
    );

    typedef struct {
        logic [15:0] data;
        logic [2:0]  idx;
        logic        hd;
    } exp_t;

    typedef struct {
        logic [31:0] pi;
        logic [15:0] p0_first;
        logic [15:0] p7_first;
    } vec_t;

    exp_t        sb_q[$];
    logic [15:0] got_q[$];
    logic [31:0] grp_w [8];
    vec_t        vecs [4];

    int checks     = 0;
    int errors     = 0;
    int cyc        = 0;
    int lat_cyc    = -1;
    int run_len    = 0;
    int last_run   = 0;
    int resync_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Output monitor: pops the scoreboard on every valid sample.
    always @(negedge clk) begin
        exp_t e;
        if (o_resync === 1'b1) resync_cnt++;
        if (o_data_valid === 1'b1) begin
            run_len++;
            if (run_len == 1 && lat_cyc >= 0) begin
                chk("first_out_latency", 32'(cyc), 32'(lat_cyc));
                lat_cyc = -1;
            end
            if (sb_q.size() == 0) begin
                chk("unexpected_output", 32'(o_data), 32'hFFFF_FFFF);
            end else begin
                e = sb_q.pop_front();
                chk("out_data", 32'(o_data), 32'(e.data));
                chk("out_idx", 32'(o_ant_idx), 32'(e.idx));
                chk("out_fram_hd", 32'(o_fram_hd), 32'(e.hd));
                got_q.push_back(o_data);
            end
        end else begin
            if (run_len != 0) last_run = run_len;
            run_len = 0;
            chk("idle_outputs_zero", {12'd0, o_fram_hd, o_ant_idx, o_data}, 32'd0);
        end
    end

    task automatic set_words(input logic [15:0] tag);
        for (int k = 0; k < 8; k++) begin
            grp_w[k] = {16'(k) + tag, 16'h1000 + 16'(k)};
        end
    endtask

    // Reference model: last write (highest slot) to a position wins.
    task automatic push_group(input logic [31:0] pi, input bit hd);
        logic [31:0] m [8];
        logic [7:0]  mk;
        logic [2:0]  p;
        exp_t        e;
        mk = '0;
        for (int k = 0; k < 8; k++) begin
            p     = pi[4*k +: 3];
            m[p]  = grp_w[k];
            mk[p] = 1'b1;
        end
        for (int q = 0; q < 8; q++) begin
            e.idx  = 3'(q);
            e.data = mk[q] ? m[q][15:0] : 16'd0;
            e.hd   = hd && (q == 0);
            sb_q.push_back(e);
            e.data = mk[q] ? m[q][31:16] : 16'd0;
            e.hd   = 1'b0;
            sb_q.push_back(e);
        end
    endtask

    task automatic drive_word(input logic [31:0] d, input bit sel, input bit hd, input int gap);
        i_data       = d;
        i_ant8_sel   = sel;
        i_fram_hd    = hd;
        i_data_valid = 1'b1;
        @(posedge clk); #1;
        i_data_valid = 1'b0;
        i_ant8_sel   = 1'b0;
        i_fram_hd    = 1'b0;
        for (int g = 1; g < gap; g++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic send_group(input logic [31:0] pi, input bit hd, input int gap,
                              input bit expect_out, input bit chk_lat);
        if (expect_out) push_group(pi, hd);
        i_ant_posinfo = pi;
        for (int k = 0; k < 8; k++) begin
            // Slot 7 is written on the next edge; the first sample follows 2 edges later.
            if (k == 7 && chk_lat) lat_cyc = cyc + 3;
            drive_word(grp_w[k], k == 0, hd && (k == 0), gap);
        end
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((sb_q.size() != 0 || o_data_valid) && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        @(negedge clk); #1;
        chk(name, 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0;
        int n;

        vecs[0] = '{pi: 32'h7654_3210, p0_first: 16'h1000, p7_first: 16'h1007};
        vecs[1] = '{pi: 32'h0123_4567, p0_first: 16'h1007, p7_first: 16'h1000};
        vecs[2] = '{pi: 32'h0000_0000, p0_first: 16'h1007, p7_first: 16'h0000};
        vecs[3] = '{pi: 32'h3517_2604, p0_first: 16'h1001, p7_first: 16'h1004};

        asy_rst_n     = 1'b0;
        i_ant_posinfo = '0;
        i_fram_hd     = 1'b0;
        i_ant8_sel    = 1'b0;
        i_data        = '0;
        i_data_valid  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 32'(o_data_valid), 32'd0);
        chk("rst_data", 32'(o_data), 32'd0);
        chk("rst_idx", 32'(o_ant_idx), 32'd0);
        chk("rst_hd", 32'(o_fram_hd), 32'd0);
        chk("rst_ovf", 32'(o_ovf), 32'd0);
        chk("rst_resync", 32'(o_resync), 32'd0);
        asy_rst_n = 1'b1;
        @(posedge clk); #1;

        // Table of position maps, each sent as an isolated group.
        for (int i = 0; i < 4; i++) begin
            set_words(16'd0);
            got_q.delete();
            send_group(vecs[i].pi, 1'b1, 2, 1'b1, 1'b1);
            wait_drain("vec_drain");
            chk("vec_count", 32'(got_q.size()), 32'd16);
            if (got_q.size() == 16) begin
                chk("vec_pos0_first", 32'(got_q[0]), 32'(vecs[i].p0_first));
                chk("vec_pos7_first", 32'(got_q[14]), 32'(vecs[i].p7_first));
            end
        end

        // Back-to-back groups at the maximum word rate.
        last_run = 0;
        for (int g = 0; g < 3; g++) begin
            set_words(16'h0010 * 16'(g + 1));
            send_group(32'h7654_3210, 1'b1, 2, 1'b1, 1'b0);
        end
        wait_drain("gapless_drain");
        chk("gapless_run", 32'(last_run), 32'd48);
        chk("gapless_ovf", 32'(o_ovf), 32'd0);

        // Partial group of 5 words, then a new group start.
        r0 = resync_cnt;
        set_words(16'h0040);
        i_ant_posinfo = 32'h7654_3210;
        for (int k = 0; k < 5; k++) begin
            drive_word(grp_w[k], k == 0, k == 0, 2);
        end
        set_words(16'h0045);
        send_group(32'h7654_3210, 1'b1, 2, 1'b1, 1'b1);
        wait_drain("resync_drain");
        chk("resync_pulses", 32'(resync_cnt - r0), 32'd1);

        // Three groups at 1-cycle spacing: the third finds its bank still full.
        last_run = 0;
        set_words(16'h0050);
        send_group(32'h0123_4567, 1'b1, 1, 1'b1, 1'b0);
        set_words(16'h0060);
        send_group(32'h0123_4567, 1'b1, 1, 1'b1, 1'b0);
        set_words(16'h0070);
        send_group(32'h0123_4567, 1'b1, 1, 1'b0, 1'b0);
        wait_drain("ovf_drain");
        chk("ovf_set", 32'(o_ovf), 32'd1);
        chk("ovf_run", 32'(last_run), 32'd32);

        // Reset in the middle of a read burst.
        set_words(16'h0080);
        got_q.delete();
        send_group(32'h7654_3210, 1'b1, 2, 1'b1, 1'b0);
        n = 0;
        while (got_q.size() < 4 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("midread_reached", 32'(got_q.size() >= 4), 32'd1);
        asy_rst_n = 1'b0;
        sb_q.delete();
        #1;
        chk("midread_rst_valid", 32'(o_data_valid), 32'd0);
        chk("midread_rst_data", 32'(o_data), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("midread_rst_ovf", 32'(o_ovf), 32'd0);
        asy_rst_n = 1'b1;
        @(posedge clk); #1;
        // Words without a group start are ignored after reset.
        i_ant_posinfo = 32'h7654_3210;
        for (int k = 0; k < 3; k++) begin
            drive_word(32'hDEAD_0000 + 32'(k), 1'b0, 1'b0, 2);
        end
        set_words(16'h0090);
        send_group(32'h0123_4567, 1'b1, 2, 1'b1, 1'b1);
        wait_drain("post_rst_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lte_dl_path_detrans.md
LTE_DL_PATH_DETRANS -- requirements
Module: lte_dl_path_detrans

Interface
REQ-001 Parameter SAMP_W, default 16, sets the sample width; the input word width is 2*SAMP_W.
REQ-002 The block SHALL use one clock and an asynchronous, active-low reset; there is no other clock or reset.
REQ-003 clk  in  1  sole clock; all logic is rising-edge.
REQ-004 asy_rst_n  in  1  asynchronous active-low reset.
REQ-005 i_ant_posinfo  in  32  antenna position map; nibble k, bits [4k+2:4k], is the physical position of slot k.
REQ-006 i_fram_hd  in  1  frame header; one-cycle pulse coincident with the first valid word of a frame.
REQ-007 i_ant8_sel  in  1  marks slot 0 of each 8-slot antenna group; sampled only when i_data_valid=1.
REQ-008 i_data  in  2*SAMP_W  sample pair {second, first}.
REQ-009 i_data_valid  in  1  word qualifier; at most one valid word per 2 cycles.
REQ-010 o_fram_hd  out  1  asserted with the first output sample of a frame.
REQ-011 o_ant_idx  out  3  physical antenna position of o_data.
REQ-012 o_data  out  SAMP_W  serialized sample.
REQ-013 o_data_valid  out  1  qualifies o_data, o_ant_idx and o_fram_hd.
REQ-014 o_ovf  out  1  sticky overflow flag.
REQ-015 o_resync  out  1  one-cycle pulse when a partial group is discarded.

Function
REQ-016 i_ant_posinfo SHALL be registered only on a valid word with i_fram_hd=1, and held for the whole frame.
REQ-017 The write slot counter (0..7) SHALL advance on each valid word; i_ant8_sel=1 forces slot 0.
REQ-018 A valid word in slot k SHALL be written into the active write bank at address posinfo[4k+2:4k], and that address SHALL be marked written.
REQ-019 The buffer SHALL be two banks (ping-pong), each 8 entries x 2*SAMP_W, with an 8-bit written-mask per bank.
REQ-020 When slot 7 is written, the bank SHALL be marked full and the write bank SHALL toggle.
REQ-021 If i_ant8_sel=1 arrives with the slot counter not at 0, the partial bank SHALL be discarded (mask cleared, no toggle) and o_resync SHALL pulse.
REQ-022 The reader FSM SHALL have two states, IDLE and READ. IDLE->READ when a full bank is pending. READ lasts exactly 16 cycles. READ->IDLE at the end unless the other bank is full, in which case READ continues on that bank with no gap.
REQ-023 In READ, for position p=0..7, the block SHALL output the first sample then the second sample, with o_ant_idx=p.
REQ-024 For a position whose mask bit is clear, the block SHALL output o_data=0 with o_data_valid=1.
REQ-025 If duplicate positions occur in posinfo, the higher slot SHALL win.
REQ-026 The first o_data_valid SHALL occur 2 cycles after the clk edge that writes slot 7.
REQ-027 o_fram_hd SHALL assert only on the first output cycle of a bank whose slot-0 word carried i_fram_hd.
REQ-028 When the reader finishes a bank, it SHALL clear that bank's mask and full flag.
REQ-029 If slot 7 completes while the target bank is still full and not yet read, the new group SHALL be dropped (no toggle, mask cleared) and o_ovf SHALL set and remain set until reset.
REQ-030 Outside READ, o_data_valid=0, o_data=0, o_ant_idx=0 and o_fram_hd=0.

Reset
REQ-031 While asy_rst_n=0, the block SHALL clear all outputs, slot counter, masks, full flags, bank pointers, FSM=IDLE and the posinfo register.
REQ-032 Reset assertion mid-READ SHALL abort the output immediately; after release, the first group SHALL be accepted only from a valid i_ant8_sel=1.
REQ-033 Buffer data contents are not reset; the masks guarantee that stale data is never output.

Configuration
REQ-034 Macro LTE_DL_DETRANS_SWAP_EN: when defined, the output order within each position SHALL be the second sample then the first; when undefined, the first then the second (REQ-023). Latency is unchanged.

Verification
REQ-035 Identity map posinfo=0x76543210; 8 words 0x000k_100k, one per 2 cycles, with hd on slot 0 -> 16 outputs 0x1000,0x0000,0x1001,0x0001,..., o_fram_hd on the first only, first output 2 cycles after slot 7.
REQ-036 posinfo=0x01234567 with the same data -> o_ant_idx 0 carries 0x1007/0x0007, and o_ant_idx 7 carries 0x1000/0x0000.
REQ-037 posinfo=0x00000000 -> position 0 outputs the slot-7 data; positions 1..7 output 0.
REQ-038 i_ant8_sel at slot 5 -> o_resync pulses once, no output for the partial group, and the next full group is output normally.
REQ-039 Continuous groups at the maximum rate -> gapless 16-cycle bursts and o_ovf=0; a group injected at 1-cycle word spacing -> o_ovf=1, the dropped group is absent, and earlier output is intact.
REQ-040 asy_rst_n low for 3 cycles mid-READ -> outputs 0 on the next cycle; the group after release outputs correctly.
